// File: rtl/mimi_wb_loader.sv
// mimi_wb_loader: Wishbone loader for the mimi SRAM banks with minimax reset hold and error CSRs.
// Byte-lane writes become full-word SRAM writes through read-modify-write.
module mimi_wb_loader #(
    parameter logic [15:0] BASE_HI    = 16'h3000,
    parameter int          RAM_BYTES  = 6144,
    parameter logic [15:0] CSR_OFFSET = 16'h8000,
    parameter int          ADDR_BITS  = 13
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 wbs_cyc_i,
    input  logic                 wbs_stb_i,
    input  logic                 wbs_we_i,
    input  logic [3:0]           wbs_sel_i,
    input  logic [31:0]          wbs_adr_i,
    input  logic [31:0]          wbs_dat_i,
    output logic                 wbs_ack_o,
    output logic [31:0]          wbs_dat_o,
    output logic                 cpu_reset_o,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [ADDR_BITS-1:0] mem_addr_o,
    output logic [31:0]          mem_wdata_o,
    input  logic [31:0]          mem_rdata_i
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, ACK} state_t;
    state_t state, state_nx;
    logic [ADDR_BITS-1:2] adr_q;
    logic [31:0] dat_q, rbuf_q;
    logic [3:0] sel_q;
    logic we_q, hold, err;
    logic valid, is_ram, is_ctrl, is_stat, accept;
    always_comb begin
        valid   = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:16] == BASE_HI);
        is_ram  = {16'h0, wbs_adr_i[15:0]} < 32'(RAM_BYTES);
        is_ctrl = wbs_adr_i[15:0] == CSR_OFFSET;
        is_stat = wbs_adr_i[15:0] == CSR_OFFSET + 16'd4;
        accept  = (state == IDLE) & valid;
    end
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (valid) state_nx = (is_ram & hold & ~(wbs_we_i & (wbs_sel_i == 4'h0)))
                                         ? ((wbs_we_i & (wbs_sel_i == 4'hF)) ? WRITE : READ) : ACK;
            READ:  state_nx = we_q ? WRITE : ACK;
            WRITE: state_nx = ACK;
            ACK:   state_nx = IDLE;
        endcase
    end
    // Memory strobes drop combinationally with reset so an interrupted write never reaches the SRAM.
    always_comb begin
        wbs_ack_o   = state == ACK;
        mem_req_o   = ~wb_rst_i & ((state == READ) | (state == WRITE));
        mem_we_o    = ~wb_rst_i & (state == WRITE);
        mem_addr_o  = {adr_q, 2'b00};
        cpu_reset_o = wb_rst_i | hold;
        mem_wdata_o = '0;
        for (int i = 0; i < 4; i++)
            mem_wdata_o[8*i +: 8] = (state == WRITE) ? (sel_q[i] ? dat_q[8*i +: 8] : rbuf_q[8*i +: 8]) : 8'h0;
    end
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            we_q      <= 1'b0;
            rbuf_q    <= '0;
            wbs_dat_o <= '0;
            hold      <= 1'b1;
            err       <= 1'b0;
        end else begin
            if (accept) begin
                adr_q     <= wbs_adr_i[ADDR_BITS-1:2];
                dat_q     <= wbs_dat_i;
                sel_q     <= wbs_sel_i;
                we_q      <= wbs_we_i;
                wbs_dat_o <= wbs_we_i ? 32'h0 : is_ctrl ? {31'h0, hold} : is_stat ? {30'h0, err, hold} : 32'h0;
                if (wbs_we_i & wbs_sel_i[0] & is_ctrl) hold <= wbs_dat_i[0];
                if (wbs_we_i & wbs_sel_i[0] & is_stat & wbs_dat_i[1]) err <= 1'b0;
                if (is_ram & ~hold) err <= 1'b1;
            end
            if (state == READ) begin
                rbuf_q <= mem_rdata_i;
                if (!we_q) wbs_dat_o <= mem_rdata_i;
            end
        end
    end
endmodule

// File: tb/tb_mimi_wb_loader.sv
// tb_mimi_wb_loader: directed checks of the loader against a falling-edge SRAM model.
module tb_mimi_wb_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0] sel = 4'h0;
    logic [31:0] adr = 32'h0, dat = 32'h0;
    logic ack, cpu_reset, mem_req, mem_we;
    logic [31:0] dat_o, mem_wdata, mem_rdata;
    logic [12:0] mem_addr;
    logic [31:0] mem [0:2047];
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    mimi_wb_loader dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
        .cpu_reset_o(cpu_reset), .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    always @(negedge clk) begin
        if (mem_req) begin
            if (mem_we) mem[mem_addr[12:2]] <= mem_wdata;
            else mem_rdata <= mem[mem_addr[12:2]];
        end
    end

    // Issues one request and reports ack latency (0 = never acked within 8 cycles) and SRAM activity.
    task automatic xfer(input logic w, input logic [3:0] s, input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] rd, output int reqs, output int wes,
                        output logic [31:0] wd, output logic [12:0] wa);
        lat = 0; rd = 32'h0; reqs = 0; wes = 0; wd = 32'h0; wa = 13'h0;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; dat = d;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (mem_req) reqs++;
            if (mem_we) begin wes++; wd = mem_wdata; wa = mem_addr; end
            if (ack) begin lat = k; rd = dat_o; break; end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        total++; if (ack !== 1'b0) begin bad++; $display("FAIL rst_ack got=%b exp=0", ack); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_mem_req got=%b exp=0", mem_req); end
        total++; if (cpu_reset !== 1'b1) begin bad++; $display("FAIL rst_cpu_reset got=%b exp=1", cpu_reset); end
        total++; if (dat_o !== 32'h0) begin bad++; $display("FAIL rst_dat got=%h exp=0", dat_o); end
        rst = 1'b0;
        #1;
        total++; if (cpu_reset !== 1'b1) begin bad++; $display("FAIL post_rst_cpu_reset got=%b exp=1", cpu_reset); end
    endtask

    task automatic test_status_after_reset();
        int lat, reqs, wes; logic [31:0] rd, wd; logic [12:0] wa;
        xfer(1'b0, 4'hF, 32'h3000_8004, 32'h0, lat, rd, reqs, wes, wd, wa);
        total++; if (lat !== 1) begin bad++; $display("FAIL status_lat got=%0d exp=1", lat); end
        total++; if (rd !== 32'h1) begin bad++; $display("FAIL status_data got=%h exp=00000001", rd); end
        total++; if (cpu_reset !== 1'b1) begin bad++; $display("FAIL status_cpu_reset got=%b exp=1", cpu_reset); end
    endtask

    task automatic test_full_write();
        int lat, reqs, wes; logic [31:0] rd, wd; logic [12:0] wa;
        xfer(1'b1, 4'hF, 32'h3000_0804, 32'hDEAD_BEEF, lat, rd, reqs, wes, wd, wa);
        total++; if (lat !== 2) begin bad++; $display("FAIL fw_lat got=%0d exp=2", lat); end
        total++; if (wes !== 1) begin bad++; $display("FAIL fw_we_pulses got=%0d exp=1", wes); end
        total++; if (reqs !== 1) begin bad++; $display("FAIL fw_reqs got=%0d exp=1", reqs); end
        total++; if (wa !== 13'h804) begin bad++; $display("FAIL fw_addr got=%h exp=0804", wa); end
        total++; if (wd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL fw_wdata got=%h exp=deadbeef", wd); end
        xfer(1'b0, 4'hF, 32'h3000_0804, 32'h0, lat, rd, reqs, wes, wd, wa);
        total++; if (lat !== 2) begin bad++; $display("FAIL rd_lat got=%0d exp=2", lat); end
        total++; if (rd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rd_data got=%h exp=deadbeef", rd); end
        total++; if (wes !== 0) begin bad++; $display("FAIL rd_we_pulses got=%0d exp=0", wes); end
    endtask

    task automatic test_partial_write();
        int lat, reqs, wes; logic [31:0] rd, wd; logic [12:0] wa;
        xfer(1'b1, 4'hF, 32'h3000_1000, 32'h1122_3344, lat, rd, reqs, wes, wd, wa);
        xfer(1'b1, 4'b0101, 32'h3000_1000, 32'hAABB_CCDD, lat, rd, reqs, wes, wd, wa);
        total++; if (lat !== 3) begin bad++; $display("FAIL pw_lat got=%0d exp=3", lat); end
        total++; if (reqs !== 2) begin bad++; $display("FAIL pw_reqs got=%0d exp=2", reqs); end
        total++; if (wes !== 1) begin bad++; $display("FAIL pw_we_pulses got=%0d exp=1", wes); end
        total++; if (wd !== 32'h11BB_33DD) begin bad++; $display("FAIL pw_wdata got=%h exp=11bb33dd", wd); end
        xfer(1'b0, 4'hF, 32'h3000_1000, 32'h0, lat, rd, reqs, wes, wd, wa);
        total++; if (rd !== 32'h11BB_33DD) begin bad++; $display("FAIL pw_readback got=%h exp=11bb33dd", rd); end
        xfer(1'b1, 4'b1000, 32'h3000_1000, 32'h7700_0000, lat, rd, reqs, wes, wd, wa);
        total++; if (wd !== 32'h77BB_33DD) begin bad++; $display("FAIL pw_lane3 got=%h exp=77bb33dd", wd); end
        xfer(1'b1, 4'h0, 32'h3000_1000, 32'hFFFF_FFFF, lat, rd, reqs, wes, wd, wa);
        total++; if (lat !== 1 || reqs !== 0) begin bad++; $display("FAIL sel0_write lat=%0d reqs=%0d exp lat=1 reqs=0", lat, reqs); end
    endtask

    task automatic test_withdraw();
        int lat = 0;
        logic [31:0] rd = 32'h0;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h3000_0804;
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (ack) begin lat = k; rd = dat_o; break; end
            @(posedge clk); #1;
        end
        total++; if (lat !== 2) begin bad++; $display("FAIL wd_lat got=%0d exp=2", lat); end
        total++; if (rd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL wd_data got=%h exp=deadbeef", rd); end
    endtask

    task automatic test_release();
        int lat, reqs, wes; logic [31:0] rd, wd; logic [12:0] wa;
        xfer(1'b1, 4'hF, 32'h3000_0000, 32'h5A5A_5A5A, lat, rd, reqs, wes, wd, wa);
        xfer(1'b1, 4'h1, 32'h3000_8000, 32'h0, lat, rd, reqs, wes, wd, wa);
        total++; if (lat !== 1) begin bad++; $display("FAIL ctrl_lat got=%0d exp=1", lat); end
        @(posedge clk); #1;
        total++; if (cpu_reset !== 1'b0) begin bad++; $display("FAIL released_cpu_reset got=%b exp=0", cpu_reset); end
        xfer(1'b0, 4'hF, 32'h3000_0000, 32'h0, lat, rd, reqs, wes, wd, wa);
        total++; if (lat !== 1) begin bad++; $display("FAIL blocked_lat got=%0d exp=1", lat); end
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL blocked_data got=%h exp=0", rd); end
        total++; if (reqs !== 0) begin bad++; $display("FAIL blocked_reqs got=%0d exp=0", reqs); end
        xfer(1'b0, 4'hF, 32'h3000_8004, 32'h0, lat, rd, reqs, wes, wd, wa);
        total++; if (rd !== 32'h2) begin bad++; $display("FAIL err_status got=%h exp=00000002", rd); end
        xfer(1'b1, 4'h1, 32'h3000_8004, 32'h2, lat, rd, reqs, wes, wd, wa);
        xfer(1'b0, 4'hF, 32'h3000_8004, 32'h0, lat, rd, reqs, wes, wd, wa);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL cleared_status got=%h exp=0", rd); end
        xfer(1'b1, 4'h1, 32'h3000_8000, 32'h1, lat, rd, reqs, wes, wd, wa);
        @(posedge clk); #1;
        total++; if (cpu_reset !== 1'b1) begin bad++; $display("FAIL rehold_cpu_reset got=%b exp=1", cpu_reset); end
        xfer(1'b0, 4'hF, 32'h3000_0000, 32'h0, lat, rd, reqs, wes, wd, wa);
        total++; if (rd !== 32'h5A5A_5A5A) begin bad++; $display("FAIL sram_kept got=%h exp=5a5a5a5a", rd); end
    endtask

    task automatic test_unmapped();
        int lat, reqs, wes; logic [31:0] rd, wd; logic [12:0] wa;
        xfer(1'b0, 4'hF, 32'h3000_1800, 32'h0, lat, rd, reqs, wes, wd, wa);
        total++; if (lat !== 1 || rd !== 32'h0 || reqs !== 0) begin bad++; $display("FAIL oob_read lat=%0d data=%h reqs=%0d exp 1/0/0", lat, rd, reqs); end
        xfer(1'b1, 4'hF, 32'h3000_9000, 32'h1234_5678, lat, rd, reqs, wes, wd, wa);
        total++; if (lat !== 1 || reqs !== 0) begin bad++; $display("FAIL hole_write lat=%0d reqs=%0d exp 1/0", lat, reqs); end
        xfer(1'b0, 4'hF, 32'h3000_9000, 32'h0, lat, rd, reqs, wes, wd, wa);
        total++; if (lat !== 1 || rd !== 32'h0) begin bad++; $display("FAIL hole_read lat=%0d data=%h exp 1/0", lat, rd); end
        xfer(1'b0, 4'hF, 32'h3100_0000, 32'h0, lat, rd, reqs, wes, wd, wa);
        total++; if (lat !== 0 || reqs !== 0) begin bad++; $display("FAIL foreign_base lat=%0d reqs=%0d exp never acked", lat, reqs); end
        xfer(1'b0, 4'hF, 32'h3000_8004, 32'h0, lat, rd, reqs, wes, wd, wa);
        total++; if (rd !== 32'h1) begin bad++; $display("FAIL unmapped_no_err got=%h exp=00000001", rd); end
    endtask

    task automatic test_reset_mid_write();
        int lat, reqs, wes; logic [31:0] rd, wd; logic [12:0] wa;
        int acks = 0;
        xfer(1'b1, 4'hF, 32'h3000_1100, 32'hCAFE_F00D, lat, rd, reqs, wes, wd, wa);
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'b0011; adr = 32'h3000_1100; dat = 32'h1234_5678;
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL rmw_in_write got=%b exp=1", mem_we); end
        rst = 1'b1;
        #1;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rmw_req_in_rst got=%b exp=0", mem_req); end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (ack) acks++;
        end
        total++; if (acks !== 0) begin bad++; $display("FAIL rmw_rst_acks got=%0d exp=0", acks); end
        total++; if (mem_req !== 1'b0 || cpu_reset !== 1'b1) begin bad++; $display("FAIL rmw_rst_state req=%b cpu_reset=%b exp 0/1", mem_req, cpu_reset); end
        rst = 1'b0;
        xfer(1'b0, 4'hF, 32'h3000_1100, 32'h0, lat, rd, reqs, wes, wd, wa);
        total++; if (rd !== 32'hCAFE_F00D && rd !== 32'hCAFE_5678) begin bad++; $display("FAIL rmw_word got=%h exp=cafef00d or cafe5678", rd); end
        xfer(1'b0, 4'hF, 32'h3000_8004, 32'h0, lat, rd, reqs, wes, wd, wa);
        total++; if (rd !== 32'h1) begin bad++; $display("FAIL rmw_status got=%h exp=00000001", rd); end
    endtask

    initial begin
        test_reset();
        test_status_after_reset();
        test_full_write();
        test_partial_write();
        test_withdraw();
        test_release();
        test_unmapped();
        test_reset_mid_write();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mimi_wb_loader.md
Name: mimi_wb_loader

Overview:
- Wishbone slave that sits upstream of the mimi SRAM banks and the minimax core's reset.
- Lets the management SoC load and inspect program memory while the core is held in reset, then releases the core.
- Converts byte-lane Wishbone writes into the full-word-only SRAM write interface using read-modify-write.
- Provides a small CSR page for core hold control and error status.

Parameters:
- BASE_HI, 16'h3000: wbs_adr_i[31:16] value that selects this slave.
- RAM_BYTES, 6144: size of the SRAM window in bytes (3 banks x 2048).
- CSR_OFFSET, 16'h8000: wbs_adr_i[15:0] base of the CSR page.
- ADDR_BITS, 13: width of mem_addr_o (byte address).

Ports:
- wb_clk_i  in  1  sole clock; SRAM macros sample on its falling edge.
- wb_rst_i  in  1  synchronous, active-high reset.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte lane selects.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  one-cycle acknowledge.
- wbs_dat_o  out  32  read data; valid only while wbs_ack_o=1.
- cpu_reset_o  out  1  reset to minimax, equal to wb_rst_i | hold.
- mem_req_o  out  1  loader owns the SRAM port this cycle.
- mem_we_o  out  1  full-word write (drives SRAM wen path).
- mem_addr_o  out  ADDR_BITS  word-aligned byte address; bits [1:0]=0.
- mem_wdata_o  out  32  write word.
- mem_rdata_i  in  32  SRAM read word, valid at the rising edge ending a mem_req_o=1, mem_we_o=0 cycle.

Behaviour:
- Clock and reset: one clock, wb_clk_i. Reset wb_rst_i is synchronous and active-high. All state is registered on the wb_clk_i rising edge.
- Reset values: state=IDLE, wbs_ack_o=0, wbs_dat_o=0, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, hold=1, err=0. cpu_reset_o=1 during and after reset.
- Select: valid = cyc & stb & adr[31:16]==BASE_HI. Otherwise the request is ignored and never acked.
- Decode of adr[15:0]:
  - RAM: below RAM_BYTES.
  - CTRL: CSR_OFFSET+0. Bit0 = hold, R/W. Write takes effect when sel[0]=1.
  - STATUS: CSR_OFFSET+4. Bit0 = hold (RO). Bit1 = err (sticky). Writing 1 to bit1 with sel[0]=1 clears err.
  - Anything else: reads return 0, writes are dropped.
- FSM states: IDLE, READ, WRITE, ACK. Acceptance happens in IDLE when valid; call that cycle N.
  - CSR, unmapped, sel=0 write, or RAM access while hold=0: go to ACK. Ack in N+1; no memory access.
  - RAM access while hold=0 also sets err; reads return 0, writes are dropped.
  - RAM read, hold=1: READ in N+1 (mem_req_o=1, mem_we_o=0). Capture mem_rdata_i into wbs_dat_o at the end of N+1. Ack in N+2.
  - RAM write, sel=4'hF: WRITE in N+1 (mem_req_o=1, mem_we_o=1, mem_wdata_o=wbs_dat_i). Ack in N+2.
  - RAM write, partial sel: READ in N+1, then WRITE in N+2. In WRITE, mem_wdata_o lane i = sel[i] ? dat_i lane : read lane. Ack in N+3.
- Request latching: address, data, sel and we are latched at acceptance. Wishbone inputs are not re-sampled mid-transaction.
- Ack: a single-cycle pulse, then return to IDLE. A new request is accepted no earlier than the cycle after ack, so there is at most one outstanding transaction.
- Master withdrawal: if cyc/stb drops mid-transaction, the memory operation still completes and ack still pulses.
- Memory outputs: mem_req_o is 0 in IDLE and ACK. mem_addr_o = latched adr[ADDR_BITS-1:2],2'b00.
- hold changes: a CTRL write updates hold at the ack edge, and cpu_reset_o follows in the next cycle. Clearing hold releases the core. Setting hold reasserts core reset; the SRAM is not cleared.
- err priority: a simultaneous err-set (blocked RAM access) and err-clear cannot occur, because only one access is outstanding.
- Reset mid-operation: abort immediately to reset values. No ack is issued and no partial write is issued after the reset edge.

Test Plan:
- Reset, then read STATUS -> ack in N+1, wbs_dat_o=32'h1, cpu_reset_o=1.
- Write 0xDEADBEEF sel=F to 0x3000_0804, then read it back -> write ack N+2 with exactly one mem_we_o pulse at mem_addr_o=0x804; read ack N+2, data 0xDEADBEEF.
- With word 0x11223344 at 0x3000_1000, write sel=4'b0101, dat=0xAABBCCDD -> READ cycle then WRITE with mem_wdata_o=0x11BB33DD; ack N+3.
- Write CTRL=0, then RAM read at 0x3000_0000 -> cpu_reset_o=0; read acks N+1 with data 0, no mem_req_o, STATUS=32'h2. Write STATUS=2 -> STATUS reads 0.
- Access 0x3000_1800 and 0x3000_9000 -> ack N+1, read 0, no mem_req_o; access at 0x3100_0000 -> never acked.
- Assert wb_rst_i during the WRITE cycle of a partial write -> no ack, mem_req_o=0 on the next edge, hold=1, and memory word unchanged (or fully written if the WRITE edge already passed).
